// File: rtl/width_packer.sv
// width_packer: packs WIDTH_IN-bit beats little-endian into WIDTH_OUT-bit words behind a one-entry registered output.
// Defining PACKER_FLUSH_EN compiles in the partial-word flush; otherwise the flush port is ignored.
module width_packer #(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH_IN-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [WIDTH_OUT-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_partial,
  output logic [15:0]          word_count
);
  localparam int RATIO = (WIDTH_IN > 0) ? (WIDTH_OUT / WIDTH_IN) : 0;
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  if (WIDTH_IN < 1 || RATIO < 1 || (WIDTH_OUT % WIDTH_IN) != 0) begin : gBadParams
    $error("width_packer: WIDTH_OUT must be a positive integer multiple of WIDTH_IN");
  end

  logic [WIDTH_OUT-1:0] acc_q, acc_d;
  logic [WIDTH_OUT-1:0] outData_q, outData_d;
  logic [WIDTH_OUT-1:0] merged;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 outValid_q, outValid_d;
  logic                 partial_q, partial_d;
  logic [15:0]          count_q, count_d;
  logic                 free, accept, complete, flushFire, load, handshake;

  assign free      = !outValid_q || out_ready;
  assign in_ready  = (cnt_q != LAST) || free;
  assign accept    = in_valid && in_ready;
  assign complete  = accept && (cnt_q == LAST);
  assign handshake = outValid_q && out_ready;
  // Slices above cnt are always zero, so OR-ing the shifted beat in is a clean merge.
  assign merged    = acc_q | (WIDTH_OUT'(in_data) << (cnt_q * WIDTH_IN));

`ifdef PACKER_FLUSH_EN
  assign flushFire = flush && free && ((cnt_q != '0) || accept);
`else
  logic unusedFlush;
  assign unusedFlush = flush;
  assign flushFire   = 1'b0;
`endif

  assign load = complete || flushFire;

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    partial_d  = partial_q;
    count_d    = handshake ? (count_q + 16'd1) : count_q;
    if (handshake) begin
      outValid_d = 1'b0;
    end
    // A load in the same cycle as a handshake overrides the clear, so no bubble.
    if (load) begin
      outData_d  = accept ? merged : acc_q;
      outValid_d = 1'b1;
      partial_d  = !complete;
      acc_d      = '0;
      cnt_d      = '0;
    end else if (accept) begin
      acc_d = merged;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      partial_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      partial_q  <= partial_d;
      count_q    <= count_d;
    end
  end

  assign out_data    = outData_q;
  assign out_valid   = outValid_q;
  assign out_partial = partial_q;
  assign word_count  = count_q;

endmodule
